fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the program counter (PCF) and the IF/ID pipeline register. Drives the instruction-memory address and captures the returned word into Decode. Obeys StallF/StallD/FlushD from the hazard unit and PCSrc_E/PCTarget_E from Execute. Keeps three free-running event counters for performance debug.

---
 rtl/rv_pkg.sv | 11 +
 rtl/pc_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants used by the fetch stage.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;
    // Redirect targets are forced onto a word boundary.
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: reset, redirect, stall and sequential-advance priority.
module pc_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pcPlus4F
);

    logic [XLEN-1:0] pcF_r;
    logic [XLEN-1:0] pcNext_s;
    logic [XLEN-1:0] pcPlus4_s;

    assign pcPlus4_s = pcF_r + PC_STEP;

    // Next-PC selection; a redirect wins over a stall so it is never lost.
    always_comb begin
        pcNext_s = pcPlus4_s;
        if (pcSrcE) begin
            pcNext_s = pcTargetE & WORD_MASK;
        end else if (stallF) begin
            pcNext_s = pcF_r;
        end else begin
            pcNext_s = pcPlus4_s;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcF_r <= RESET_PC;
        end else begin
            pcF_r <= pcNext_s;
        end
    end

    assign pcF      = pcF_r;
    assign pcPlus4F = pcPlus4_s;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, IF/ID pipeline register and debug event counters.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [XLEN-1:0] cnt_fetch,
    output logic [XLEN-1:0] cnt_stall,
    output logic [XLEN-1:0] cnt_flush
);

    logic [XLEN-1:0] pcF_s;
    logic [XLEN-1:0] pcPlus4F_s;
    logic [XLEN-1:0] instrD_r;
    logic [XLEN-1:0] pcD_r;
    logic [XLEN-1:0] pcPlus4D_r;
    logic            validD_r;
    logic [XLEN-1:0] cntFetch_r;
    logic [XLEN-1:0] cntStall_r;
    logic [XLEN-1:0] cntFlush_r;
    logic            loadD_s;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .stallF    (StallF),
        .pcSrcE    (PCSrc_E),
        .pcTargetE (PCTarget_E),
        .pcF       (pcF_s),
        .pcPlus4F  (pcPlus4F_s)
    );

    assign loadD_s = ~FlushD & ~StallD;

    // IF/ID register; a flush bubbles even when Decode is stalled.
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            instrD_r   <= NOP_INSTR;
            pcD_r      <= 32'h0000_0000;
            pcPlus4D_r <= 32'h0000_0000;
            validD_r   <= 1'b0;
        end else if (StallD) begin
            instrD_r   <= instrD_r;
            pcD_r      <= pcD_r;
            pcPlus4D_r <= pcPlus4D_r;
            validD_r   <= validD_r;
        end else begin
            instrD_r   <= imem_rdata;
            pcD_r      <= pcF_s;
            pcPlus4D_r <= pcPlus4F_s;
            validD_r   <= 1'b1;
        end
    end

    // Free-running, wrapping performance counters; several may step together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntFetch_r <= 32'h0000_0000;
            cntStall_r <= 32'h0000_0000;
            cntFlush_r <= 32'h0000_0000;
        end else begin
            cntFetch_r <= loadD_s ? cntFetch_r + 32'h0000_0001 : cntFetch_r;
            cntStall_r <= StallF  ? cntStall_r + 32'h0000_0001 : cntStall_r;
            cntFlush_r <= FlushD  ? cntFlush_r + 32'h0000_0001 : cntFlush_r;
        end
    end

    assign imem_addr = pcF_s;
    assign InstrD    = instrD_r;
    assign PCD       = pcD_r;
    assign PCPlus4D  = pcPlus4D_r;
    assign ValidD    = validD_r;
    assign cnt_fetch = cntFetch_r;
    assign cnt_stall = cntStall_r;
    assign cnt_flush = cntFlush_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model pushes the expected post-edge state
// for every driven cycle, and it is popped and compared against the DUT after the edge.
module tb_fetch_stage;

    localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] cf;
        logic [31:0] cs;
        logic [31:0] cfl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stallF, stallD, flushD, pcSrcE;
    logic [31:0] pcTargetE;
    logic [31:0] imemAddr, imemRdata, instrD, pcD, pcPlus4D;
    logic        validD;
    logic [31:0] cntFetch, cntStall, cntFlush;

    logic        rst2;
    logic [31:0] imemAddr2, instrD2, pcD2, pcPlus4D2;
    logic        validD2;
    logic [31:0] cntFetch2, cntStall2, cntFlush2;

    int testsRun = 0;
    int testsFailed = 0;
    exp_t sbQ[$];

    // reference model state
    logic [31:0] mPc, mInstr, mPcd, mPcp4, mCf, mCs, mCfl;
    logic        mValid;

    always #5 clk = ~clk;

    assign imemRdata = imemAddr ^ IMEM_KEY;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .StallF(stallF), .StallD(stallD), .FlushD(flushD),
        .PCSrc_E(pcSrcE), .PCTarget_E(pcTargetE), .imem_addr(imemAddr),
        .imem_rdata(imemRdata), .InstrD(instrD), .PCD(pcD), .PCPlus4D(pcPlus4D),
        .ValidD(validD), .cnt_fetch(cntFetch), .cnt_stall(cntStall), .cnt_flush(cntFlush)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) dut2 (
        .clk(clk), .rst(rst2), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
        .PCSrc_E(1'b0), .PCTarget_E(32'h0000_0000), .imem_addr(imemAddr2),
        .imem_rdata(imemAddr2 ^ IMEM_KEY), .InstrD(instrD2), .PCD(pcD2),
        .PCPlus4D(pcPlus4D2), .ValidD(validD2), .cnt_fetch(cntFetch2),
        .cnt_stall(cntStall2), .cnt_flush(cntFlush2)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, advance the model, push expectation, clock, pop and compare.
    task automatic cycle(input logic r, input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] nPc;
        rst = r; stallF = sf; stallD = sd; flushD = fd; pcSrcE = ps; pcTargetE = tgt;
        if (r)       nPc = 32'h0000_0000;
        else if (ps) nPc = {tgt[31:2], 2'b00};
        else if (sf) nPc = mPc;
        else         nPc = mPc + 32'd4;
        if (r || fd) begin
            mInstr = 32'h0000_0013; mPcd = 32'd0; mPcp4 = 32'd0; mValid = 1'b0;
        end else if (!sd) begin
            mInstr = mPc ^ IMEM_KEY; mPcd = mPc; mPcp4 = mPc + 32'd4; mValid = 1'b1;
        end
        if (r) begin
            mCf = 32'd0; mCs = 32'd0; mCfl = 32'd0;
        end else begin
            if (!fd && !sd) mCf = mCf + 32'd1;
            if (sf)         mCs = mCs + 32'd1;
            if (fd)         mCfl = mCfl + 32'd1;
        end
        mPc = nPc;
        e = '{pc: mPc, instr: mInstr, pcd: mPcd, pcp4: mPcp4, valid: mValid,
              cf: mCf, cs: mCs, cfl: mCfl};
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            checkEq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbQ.pop_front();
            checkEq("imem_addr", imemAddr, e.pc);
            checkEq("InstrD", instrD, e.instr);
            checkEq("PCD", pcD, e.pcd);
            checkEq("PCPlus4D", pcPlus4D, e.pcp4);
            checkEq("ValidD", {31'd0, validD}, {31'd0, e.valid});
            checkEq("cnt_fetch", cntFetch, e.cf);
            checkEq("cnt_stall", cntStall, e.cs);
            checkEq("cnt_flush", cntFlush, e.cfl);
        end
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        mPc = 32'd0; mInstr = 32'h13; mPcd = 32'd0; mPcp4 = 32'd0; mValid = 1'b0;
        mCf = 32'd0; mCs = 32'd0; mCfl = 32'd0;
        rst2 = 1'b1;

        // reset, then free run 0,4,8,C,10
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkEq("rst_addr", imemAddr, 32'h0);
        checkEq("rst_instr", instrD, 32'h13);
        free(1);
        checkEq("run1_addr", imemAddr, 32'h4);
        checkEq("run1_instr", instrD, 32'hA5A5_0000);
        checkEq("run1_valid", {31'd0, validD}, 32'd1);
        free(3);
        checkEq("run4_addr", imemAddr, 32'h10);
        checkEq("run4_fetch", cntFetch, 32'd4);

        // redirect with flush at PCF=0x10
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        checkEq("redir_addr", imemAddr, 32'h100);
        checkEq("redir_bubble", instrD, 32'h13);
        checkEq("redir_flush", cntFlush, 32'd1);
        free(1);
        checkEq("redir_instr", instrD, 32'hA5A5_0100);
        checkEq("redir_pcd", pcD, 32'h100);

        // land PCF on 0x20, then a one-cycle load-use stall
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_001C);
        free(1);
        checkEq("pre_stall_addr", imemAddr, 32'h20);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checkEq("stall_addr", imemAddr, 32'h20);
        checkEq("stall_instr", instrD, 32'hA5A5_001C);
        checkEq("stall_fetch", cntFetch, 32'd6);
        checkEq("stall_cnt", cntStall, 32'd1);
        free(1);
        checkEq("post_stall_instr", instrD, 32'hA5A5_0020);

        // redirect beats stall; flush beats Decode stall
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        checkEq("stall_redir_addr", imemAddr, 32'h200);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkEq("flush_stall_valid", {31'd0, validD}, 32'd0);
        checkEq("flush_stall_instr", instrD, 32'h13);

        // random traffic, no reset
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0), $urandom);
        end

        // reset mid-stream after 5 fetches, with other inputs active
        free(5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
        checkEq("mid_rst_addr", imemAddr, 32'h0);
        checkEq("mid_rst_fetch", cntFetch, 32'd0);
        checkEq("mid_rst_stall", cntStall, 32'd0);
        checkEq("mid_rst_flush", cntFlush, 32'd0);
        free(1);
        checkEq("mid_rst_first", instrD, 32'hA5A5_0000);

        // wrap-around instance: reset PC near top of address space
        @(posedge clk); #1;
        checkEq("wrap_a0", imemAddr2, 32'hFFFF_FFF8);
        rst2 = 1'b0;
        @(posedge clk); #1;
        checkEq("wrap_a1", imemAddr2, 32'hFFFF_FFFC);
        checkEq("wrap_p4_1", pcPlus4D2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        checkEq("wrap_a2", imemAddr2, 32'h0000_0000);
        checkEq("wrap_pcd", pcD2, 32'hFFFF_FFFC);
        checkEq("wrap_p4_2", pcPlus4D2, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
